// File: rtl/vote_tally_unit.sv
// Ballot tally engine: captures one decrypted record per rising edge of dec_status,
// validates header, checksum and candidate, and keeps saturating per-candidate and summary totals.
module vote_tally_unit #(
  parameter int         NUM_CAND = 8,
  parameter int         CNT_W    = 16,
  parameter logic [7:0] MAGIC    = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:63]      dec_data,
  input  logic             dec_status,
  input  logic             freeze,
  input  logic [3:0]       rd_idx,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] total_votes,
  output logic [CNT_W-1:0] reject_count,
  output logic             accept_pulse,
  output logic             reject_pulse,
  output logic             busy
);

  localparam int               IDX_W      = $clog2(NUM_CAND);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [4:0]       NUM_CAND_V = 5'(NUM_CAND);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    COMMIT = 2'd2,
    REJECT = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  function automatic logic [15:0] rec_checksum(input logic [0:63] r);
    rec_checksum = r[0:15] ^ r[16:31] ^ r[32:47];
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic             status_r;
  logic             armed_r;
  logic [0:63]      rec_r;
  logic [CNT_W-1:0] count_r [NUM_CAND];
  logic [CNT_W-1:0] total_r;
  logic [CNT_W-1:0] reject_r;
  logic [CNT_W-1:0] rd_count_r;
  logic             accept_pulse_r;
  logic             reject_pulse_r;
  logic             busy_r;

  logic             start_s;
  logic             capture_s;
  logic [3:0]       cand_s;
  logic             hdr_ok_s;
  logic             sum_ok_s;
  logic             cand_ok_s;
  logic             rec_ok_s;

  // armed_r blocks a level that was already high across reset release from looking like an edge
  assign start_s   = dec_status & ~status_r & armed_r;
  assign cand_s    = rec_r[16:19];
  assign hdr_ok_s  = (rec_r[0:7] == MAGIC);
  assign sum_ok_s  = (rec_r[48:63] == rec_checksum(rec_r));
  assign cand_ok_s = ({1'b0, cand_s} < NUM_CAND_V);
  assign rec_ok_s  = hdr_ok_s & sum_ok_s & cand_ok_s;

  // Next-state logic
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s && !freeze) begin
          state_s   = CHECK;
          capture_s = 1'b1;
        end else begin
          state_s   = IDLE;
        end
      end
      CHECK: begin
        if (rec_ok_s) begin
          state_s = COMMIT;
        end else begin
          state_s = REJECT;
        end
      end
      COMMIT:  state_s = IDLE;
      REJECT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, edge detect, record capture and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      status_r       <= 1'b0;
      armed_r        <= 1'b0;
      rec_r          <= 64'h0;
      accept_pulse_r <= 1'b0;
      reject_pulse_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      status_r       <= dec_status;
      armed_r        <= armed_r | ~dec_status;
      if (capture_s) begin
        rec_r <= dec_data;
      end
      accept_pulse_r <= (state_s == COMMIT);
      reject_pulse_r <= (state_s == REJECT);
      busy_r         <= (state_s != IDLE);
    end
  end

  // Tallies advance on the CHECK decision so they are visible together with the pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CAND; i++) begin
        count_r[i] <= CNT_ZERO;
      end
      total_r  <= CNT_ZERO;
      reject_r <= CNT_ZERO;
    end else if (state_r == CHECK) begin
      if (rec_ok_s) begin
        count_r[cand_s[IDX_W-1:0]] <= sat_inc(count_r[cand_s[IDX_W-1:0]]);
        total_r                    <= sat_inc(total_r);
      end else begin
        reject_r <= sat_inc(reject_r);
      end
    end
  end

  // Registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_r <= CNT_ZERO;
    end else if ({1'b0, rd_idx} < NUM_CAND_V) begin
      rd_count_r <= count_r[rd_idx[IDX_W-1:0]];
    end else begin
      rd_count_r <= CNT_ZERO;
    end
  end

  assign rd_count     = rd_count_r;
  assign total_votes  = total_r;
  assign reject_count = reject_r;
  assign accept_pulse = accept_pulse_r;
  assign reject_pulse = reject_pulse_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_vote_tally_unit.sv
// Bench for vote_tally_unit: a default instance and a narrow-counter instance share stimulus
// and are checked against a transaction-level tally model with unbounded counts.
module tb_vote_tally_unit;

  localparam int NC    = 8;
  localparam int MAX_L = 65535;
  localparam int MAX_S = 63;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:63] dec_data;
  logic        dec_status;
  logic        freeze;
  logic [3:0]  rd_idx;
  logic [15:0] rd_count, total_votes, reject_count;
  logic        accept_pulse, reject_pulse, busy;
  logic [5:0]  s_rd_count, s_total, s_reject;
  logic        s_acc, s_rej, s_busy;

  int total_checks = 0;
  int bad = 0;
  int cyc = 0;
  int acc_seen = 0, rej_seen = 0, s_acc_seen = 0;
  int m_cnt [16];
  int m_tot, m_rej, m_acc_p, m_rej_p, last_cap;

  always #5 clk = ~clk;

  vote_tally_unit dut (
    .clk(clk), .rst_n(rst_n), .dec_data(dec_data), .dec_status(dec_status), .freeze(freeze),
    .rd_idx(rd_idx), .rd_count(rd_count), .total_votes(total_votes), .reject_count(reject_count),
    .accept_pulse(accept_pulse), .reject_pulse(reject_pulse), .busy(busy)
  );

  vote_tally_unit #(.CNT_W(6)) dut_s (
    .clk(clk), .rst_n(rst_n), .dec_data(dec_data), .dec_status(dec_status), .freeze(freeze),
    .rd_idx(rd_idx), .rd_count(s_rd_count), .total_votes(s_total), .reject_count(s_reject),
    .accept_pulse(s_acc), .reject_pulse(s_rej), .busy(s_busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (accept_pulse) acc_seen <= acc_seen + 1;
      if (reject_pulse) rej_seen <= rej_seen + 1;
      if (s_acc) s_acc_seen <= s_acc_seen + 1;
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [0:63] mk_rec(input logic [7:0] hdr, input logic [3:0] cand,
                                         input logic bad_sum);
    logic [0:63] r;
    r[0:7]   = hdr;
    r[8:15]  = 8'($urandom);
    r[16:19] = cand;
    r[20:47] = 28'($urandom);
    r[48:63] = r[0:15] ^ r[16:31] ^ r[32:47] ^ {15'd0, bad_sum};
    return r;
  endfunction

  function automatic bit rec_valid(input logic [0:63] r);
    logic [15:0] ck;
    ck = r[0:15] ^ r[16:31] ^ r[32:47];
    return (r[0:7] == 8'hA5) && (r[48:63] == ck) && (int'(r[16:19]) < NC);
  endfunction

  // A start edge is taken only when not frozen and at least 3 edges after the previous capture
  task automatic model_start(input logic [0:63] r);
    int e;
    e = cyc + 1;
    if (!freeze && e >= last_cap + 3) begin
      last_cap = e;
      if (rec_valid(r)) begin
        m_cnt[int'(r[16:19])]++;
        m_tot++;
        m_acc_p++;
      end else begin
        m_rej++;
        m_rej_p++;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_tot = 0;
    m_rej = 0;
    last_cap = -100;
  endtask

  task automatic send(input logic [0:63] r, input int hi, input int lo);
    dec_data = r;
    model_start(r);
    dec_status = 1'b1;
    repeat (hi) @(negedge clk);
    dec_status = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] idx, output logic [15:0] a, output logic [5:0] b);
    rd_idx = idx;
    @(negedge clk);
    a = rd_count;
    b = s_rd_count;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_checks++;
    if ({rd_count, total_votes, reject_count, accept_pulse, reject_pulse, busy} !== 51'd0) begin
      bad++;
      $display("FAIL reset_main got=%h exp=0",
               {rd_count, total_votes, reject_count, accept_pulse, reject_pulse, busy});
    end
    total_checks++;
    if ({s_rd_count, s_total, s_reject, s_acc, s_rej, s_busy} !== 21'd0) begin
      bad++;
      $display("FAIL reset_small got=%h exp=0", {s_rd_count, s_total, s_reject, s_acc, s_rej, s_busy});
    end
    rst_n = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_valid();
    logic [15:0] a;
    logic [5:0]  b;
    dec_data = 64'hA503_2000_0000_8503;
    model_start(dec_data);
    dec_status = 1'b1;
    @(negedge clk);
    total_checks++;
    if (accept_pulse !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL valid_n acc=%b busy=%b exp acc=0 busy=1", accept_pulse, busy);
    end
    dec_status = 1'b0;
    @(negedge clk);
    total_checks++;
    if (accept_pulse !== 1'b1 || s_acc !== 1'b1 || reject_pulse !== 1'b0) begin
      bad++;
      $display("FAIL valid_pulse acc=%b s_acc=%b rej=%b exp 1 1 0", accept_pulse, s_acc, reject_pulse);
    end
    @(negedge clk);
    total_checks++;
    if (accept_pulse !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL valid_end acc=%b busy=%b exp 0 0", accept_pulse, busy);
    end
    rd(4'd2, a, b);
    total_checks++;
    if (a !== 16'd1 || b !== 6'd1) begin
      bad++;
      $display("FAIL valid_rd got=%0d/%0d exp=1", a, b);
    end
    total_checks++;
    if (total_votes !== 16'd1 || reject_count !== 16'd0) begin
      bad++;
      $display("FAIL valid_tot tot=%0d rej=%0d exp 1 0", total_votes, reject_count);
    end
  endtask

  task automatic test_reject();
    logic [15:0] a;
    logic [5:0]  b;
    int          r0;
    r0 = rej_seen;
    send(mk_rec(8'h5A, 4'd3, 1'b0), 1, 4);
    send(mk_rec(8'hA5, 4'd3, 1'b1), 1, 4);
    send(mk_rec(8'hA5, 4'd9, 1'b0), 1, 4);
    total_checks++;
    if (reject_count !== 16'(m_rej) || m_rej != 3) begin
      bad++;
      $display("FAIL rej_count got=%0d exp=3", reject_count);
    end
    total_checks++;
    if (rej_seen - r0 != 3 || acc_seen != m_acc_p) begin
      bad++;
      $display("FAIL rej_pulses rej=%0d acc=%0d exp 3 %0d", rej_seen - r0, acc_seen, m_acc_p);
    end
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), a, b);
      total_checks++;
      if (a !== 16'(sat(m_cnt[i], MAX_L))) begin
        bad++;
        $display("FAIL rej_cnt[%0d] got=%0d exp=%0d", i, a, m_cnt[i]);
      end
    end
  endtask

  task automatic test_hold_high();
    logic [0:63] r;
    int          a0;
    a0 = acc_seen;
    r = mk_rec(8'hA5, 4'd5, 1'b0);
    dec_data = r;
    model_start(r);
    dec_status = 1'b1;
    @(negedge clk);
    dec_status = 1'b0;
    @(negedge clk);
    model_start(r);
    dec_status = 1'b1;
    repeat (20) @(negedge clk);
    dec_status = 1'b0;
    repeat (4) @(negedge clk);
    total_checks++;
    if (acc_seen - a0 != 1) begin
      bad++;
      $display("FAIL hold_accepts got=%0d exp=1", acc_seen - a0);
    end
    total_checks++;
    if (total_votes !== 16'(m_tot)) begin
      bad++;
      $display("FAIL hold_total got=%0d exp=%0d", total_votes, m_tot);
    end
  endtask

  task automatic test_freeze();
    int a0, r0, t0;
    a0 = acc_seen;
    r0 = rej_seen;
    t0 = m_tot;
    freeze = 1'b1;
    repeat (3) send(mk_rec(8'hA5, 4'd1, 1'b0), 1, 4);
    total_checks++;
    if (acc_seen != a0 || rej_seen != r0 || total_votes !== 16'(t0)) begin
      bad++;
      $display("FAIL freeze_hold acc=%0d tot=%0d exp %0d %0d", acc_seen - a0, total_votes, 0, t0);
    end
    freeze = 1'b0;
    send(mk_rec(8'hA5, 4'd1, 1'b0), 1, 4);
    total_checks++;
    if (total_votes !== 16'(t0 + 1) || acc_seen != a0 + 1) begin
      bad++;
      $display("FAIL freeze_release tot=%0d exp=%0d", total_votes, t0 + 1);
    end
    dec_data = mk_rec(8'hA5, 4'd6, 1'b0);
    model_start(dec_data);
    dec_status = 1'b1;
    @(negedge clk);
    freeze = 1'b1;
    dec_status = 1'b0;
    repeat (4) @(negedge clk);
    freeze = 1'b0;
    total_checks++;
    if (total_votes !== 16'(t0 + 2) || acc_seen != a0 + 2) begin
      bad++;
      $display("FAIL freeze_midrec tot=%0d exp=%0d", total_votes, t0 + 2);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [5:0]  b;
    logic [7:0]  hdr;
    logic [3:0]  cand;
    int          k;
    for (int n = 0; n < 150; n++) begin
      k    = int'($urandom_range(9));
      hdr  = (k == 0) ? 8'($urandom) : 8'hA5;
      cand = (k == 1) ? 4'($urandom) : 4'($urandom_range(NC - 1));
      freeze = ($urandom_range(7) == 0);
      send(mk_rec(hdr, cand, k == 2), int'($urandom_range(3, 1)), int'($urandom_range(3, 1)));
    end
    freeze = 1'b0;
    repeat (4) @(negedge clk);
    total_checks++;
    if (acc_seen != m_acc_p || rej_seen != m_rej_p || s_acc_seen != m_acc_p) begin
      bad++;
      $display("FAIL rand_pulses acc=%0d/%0d rej=%0d exp %0d %0d", acc_seen, s_acc_seen, rej_seen,
               m_acc_p, m_rej_p);
    end
    total_checks++;
    if (total_votes !== 16'(sat(m_tot, MAX_L)) || reject_count !== 16'(sat(m_rej, MAX_L)) ||
        s_total !== 6'(sat(m_tot, MAX_S)) || s_reject !== 6'(sat(m_rej, MAX_S))) begin
      bad++;
      $display("FAIL rand_totals tot=%0d rej=%0d s=%0d/%0d exp %0d %0d", total_votes, reject_count,
               s_total, s_reject, m_tot, m_rej);
    end
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), a, b);
      total_checks++;
      if (a !== 16'(sat(m_cnt[i], MAX_L)) || b !== 6'(sat(m_cnt[i], MAX_S))) begin
        bad++;
        $display("FAIL rand_cnt[%0d] got=%0d/%0d exp=%0d", i, a, b, m_cnt[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] a;
    logic [5:0]  b;
    int          s0;
    s0 = s_acc_seen;
    repeat (70) send(mk_rec(8'hA5, 4'd0, 1'b0), 1, 2);
    repeat (3) @(negedge clk);
    rd(4'd0, a, b);
    total_checks++;
    if (b !== 6'd63 || a !== 16'(sat(m_cnt[0], MAX_L))) begin
      bad++;
      $display("FAIL sat_cnt0 got=%0d/%0d exp=63/%0d", b, a, m_cnt[0]);
    end
    total_checks++;
    if (s_total !== 6'd63 || total_votes !== 16'(sat(m_tot, MAX_L))) begin
      bad++;
      $display("FAIL sat_total got=%0d/%0d exp=63/%0d", s_total, total_votes, m_tot);
    end
    total_checks++;
    if (s_acc_seen - s0 != 70) begin
      bad++;
      $display("FAIL sat_pulses got=%0d exp=70", s_acc_seen - s0);
    end
  endtask

  task automatic test_reset_mid();
    int a0;
    dec_data = mk_rec(8'hA5, 4'd4, 1'b0);
    dec_status = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total_checks++;
    if ({rd_count, total_votes, reject_count, accept_pulse, reject_pulse, busy} !== 51'd0 ||
        {s_total, s_acc, s_busy} !== 8'd0) begin
      bad++;
      $display("FAIL rstmid_clear got=%h exp=0", {total_votes, accept_pulse, busy, s_total});
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    a0 = acc_seen;
    repeat (6) @(negedge clk);
    total_checks++;
    if (busy !== 1'b0 || total_votes !== 16'd0 || acc_seen != a0) begin
      bad++;
      $display("FAIL rstmid_noretrig busy=%b tot=%0d exp 0 0", busy, total_votes);
    end
    dec_status = 1'b0;
    @(negedge clk);
    send(dec_data, 1, 4);
    total_checks++;
    if (total_votes !== 16'd1 || acc_seen != a0 + 1) begin
      bad++;
      $display("FAIL rstmid_rearm tot=%0d exp=1", total_votes);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    dec_data   = 64'h0;
    dec_status = 1'b0;
    freeze     = 1'b0;
    rd_idx     = 4'd0;
    m_acc_p    = 0;
    m_rej_p    = 0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_valid();
    test_reject();
    test_hold_high();
    test_freeze();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total_checks, bad);
    $finish;
  end

endmodule
